// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Function : Receive frame buffer for the UART receiver. It stores one
//            {err, byte} entry per completed frame in a circular FIFO, stops
//            new frames from starting while the buffer is full, and provides
//            a registered read port. Compile with RX_FIFO_DROP_ERR_EN defined
//            to discard errored frames instead of storing them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              rx_clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              rx_err,
  output logic              rx_start,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_err,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic              err_drop
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [8:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic              rx_done_q, empty_q, full_q, overflow_q, rx_start_q;
  logic [7:0]        rd_data_q;
  logic              rd_err_q, rd_valid_q;
  logic              push_req, push_ok, do_push, pop, drop, tag;
  logic              empty_d, full_d, overflow_d;

  // rx_done is a level that stays high for several cycles; only its rise is a frame.
  assign push_req = rx_done & ~rx_done_q;
  assign pop      = rd_en & ~empty_q;

`ifdef RX_FIFO_DROP_ERR_EN
  logic err_drop_q;
  assign push_ok  = push_req & ~rx_err;
  assign tag      = 1'b0;
  assign err_drop = err_drop_q;

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) err_drop_q <= 1'b0;
    else      err_drop_q <= push_req & rx_err;
  end
`else
  assign push_ok  = push_req;
  assign tag      = rx_err;
  assign err_drop = 1'b0;
`endif

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_ok & (~full_q | pop);
  assign drop    = push_ok & full_q & ~pop;

  always_comb begin
    level_d = level_q;
    if (do_push && !pop)      level_d = level_q + {{ADDR_W{1'b0}}, 1'b1};
    else if (!do_push && pop) level_d = level_q - {{ADDR_W{1'b0}}, 1'b1};
  end

  assign empty_d    = (level_d == '0);
  assign full_d     = (level_d == FULL_LVL);
  assign overflow_d = drop | (overflow_q & ~ovf_clr);

  always_ff @(posedge rx_clk or negedge rst) begin
    if (!rst) begin
      rx_done_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rx_start_q <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rx_done_q  <= rx_done;
      level_q    <= level_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      rx_start_q <= ~full_d;
      rd_valid_q <= pop;
      if (do_push) wr_ptr_q <= wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        rd_data_q <= mem_q[rd_ptr_q][7:0];
        rd_err_q  <= mem_q[rd_ptr_q][8];
      end
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge rx_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {tag, rx_data};
  end

  assign rx_start = rx_start_q;
  assign rd_data  = rd_data_q;
  assign rd_err   = rd_err_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Function : Self-checking bench for uart_rx_fifo: a vector table for the
//            single-frame cases plus directed fill/drain, wrap, simultaneous
//            push/pop and mid-operation reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              rx_clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_done, rx_err, rd_en, ovf_clr;
  logic              rx_start, rd_err, rd_valid, empty, full, overflow, err_drop;
  logic [7:0]        rd_data;
  logic [ADDR_W:0]   level;

  int pass_cnt  = 0;
  int total_cnt = 0;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .rx_clk   (rx_clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_err   (rx_err),
    .rx_start (rx_start),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .err_drop (err_drop)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {
    logic [15:0] reps;
    logic        done;
    logic [7:0]  data;
    logic        err;
    logic        rd;
    logic        clr;
    logic [7:0]  e_rdata;
    logic        e_rerr;
    logic        e_rvalid;
    logic        e_empty;
    logic        e_full;
    logic [4:0]  e_level;
    logic        e_ovf;
    logic        e_start;
    logic        e_edrop;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic step();
    @(posedge rx_clk);
    #1;
  endtask

  task automatic idle_inputs();
    rx_done = 1'b0; rx_data = 8'h00; rx_err = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] d);
    rx_done = 1'b1; rx_data = d; rx_err = 1'b0;
    step();
    rx_done = 1'b0;
    step();
  endtask

  initial begin
    vecs[0] = '{16'd16, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{16'd1,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'd1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'd1,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
`ifdef RX_FIFO_DROP_ERR_EN
    vecs[4] = '{16'd1,  1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{16'd1,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
`else
    vecs[4] = '{16'd1,  1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{16'd1,  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0};
`endif

    idle_inputs();
    rst = 1'b0;
    #12;
    chk("rst_start",  int'(rx_start), 0);
    chk("rst_rdata",  int'(rd_data),  0);
    chk("rst_rerr",   int'(rd_err),   0);
    chk("rst_rvalid", int'(rd_valid), 0);
    chk("rst_empty",  int'(empty),    1);
    chk("rst_full",   int'(full),     0);
    chk("rst_level",  int'(level),    0);
    chk("rst_ovf",    int'(overflow), 0);
    chk("rst_edrop",  int'(err_drop), 0);
    #2 rst = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      rx_done = vecs[v].done; rx_data = vecs[v].data; rx_err = vecs[v].err;
      rd_en = vecs[v].rd; ovf_clr = vecs[v].clr;
      for (int r = 0; r < int'(vecs[v].reps); r++) step();
      chk($sformatf("v%0d_rdata", v),  int'(rd_data),  int'(vecs[v].e_rdata));
      chk($sformatf("v%0d_rerr", v),   int'(rd_err),   int'(vecs[v].e_rerr));
      chk($sformatf("v%0d_rvalid", v), int'(rd_valid), int'(vecs[v].e_rvalid));
      chk($sformatf("v%0d_empty", v),  int'(empty),    int'(vecs[v].e_empty));
      chk($sformatf("v%0d_full", v),   int'(full),     int'(vecs[v].e_full));
      chk($sformatf("v%0d_level", v),  int'(level),    int'(vecs[v].e_level));
      chk($sformatf("v%0d_ovf", v),    int'(overflow), int'(vecs[v].e_ovf));
      chk($sformatf("v%0d_start", v),  int'(rx_start), int'(vecs[v].e_start));
      chk($sformatf("v%0d_edrop", v),  int'(err_drop), int'(vecs[v].e_edrop));
    end
    idle_inputs();
    step();
    chk("rvalid_one_cycle", int'(rd_valid), 0);
    chk("edrop_one_cycle",  int'(err_drop), 0);

    // Fill to DEPTH, then a 17th frame that must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      rx_done = 1'b1; rx_data = 8'(i);
      step();
      if (i == DEPTH - 1) begin
        chk("fill_full",  int'(full),     1);
        chk("fill_start", int'(rx_start), 0);
      end
      rx_done = 1'b0;
      step();
    end
    chk("fill_level", int'(level), DEPTH);
    push_frame(8'hFF);
    chk("ovf_set",     int'(overflow), 1);
    chk("ovf_level",   int'(level),    DEPTH);
    chk("ovf_start",   int'(rx_start), 0);
    rd_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk($sformatf("drain%0d_data", i),  int'(rd_data),  i);
      chk($sformatf("drain%0d_valid", i), int'(rd_valid), 1);
    end
    rd_en = 1'b0;
    chk("drain_empty", int'(empty),    1);
    chk("drain_start", int'(rx_start), 1);
    step();
    chk("drain_noval", int'(rd_valid), 0);
    chk("drain_hold",  int'(rd_data),  8'h0F);
    chk("ovf_sticky",  int'(overflow), 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", int'(overflow), 0);

    // Alternate push/pop past the pointer wrap.
    for (int i = 0; i < DEPTH + 5; i++) begin
      rx_done = 1'b1; rx_data = 8'(8'h40 + i);
      step();
      chk($sformatf("wrap%0d_lvl1", i), int'(level), 1);
      rx_done = 1'b0; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk($sformatf("wrap%0d_data", i), int'(rd_data), 8'h40 + i);
      chk($sformatf("wrap%0d_lvl0", i), int'(level), 0);
    end

    // Full FIFO with a push and a pop on the same edge.
    for (int i = 0; i < DEPTH; i++) push_frame(8'(8'h80 + i));
    chk("sim_pre_full", int'(full), 1);
    rx_done = 1'b1; rx_data = 8'hEE; rd_en = 1'b1;
    step();
    rx_done = 1'b0;
    chk("sim_data",  int'(rd_data),  8'h80);
    chk("sim_level", int'(level),    DEPTH);
    chk("sim_full",  int'(full),     1);
    chk("sim_ovf",   int'(overflow), 0);
    for (int i = 1; i < DEPTH; i++) begin
      step();
      chk($sformatf("sim_drain%0d", i), int'(rd_data), 8'h80 + i);
    end
    step();
    rd_en = 1'b0;
    chk("sim_last", int'(rd_data), 8'hEE);
    chk("sim_empty", int'(empty), 1);

    // Asynchronous reset with entries present.
    for (int i = 0; i < 7; i++) push_frame(8'(i + 1));
    chk("pre_rst_level", int'(level), 7);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_level", int'(level),    0);
    chk("mid_rst_empty", int'(empty),    1);
    chk("mid_rst_start", int'(rx_start), 0);
    step();
    rst = 1'b1;
    step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("post_rst_noval", int'(rd_valid), 0);
    chk("post_rst_empty", int'(empty),    1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
